fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the pipeline control/decode register.
- Owns the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake with variable latency.
- Slices each word into opcode, reg3 address and offset for the control stage.
- Handles branch redirects and pipeline stalls.
- Emits a one-cycle branch_flush to the control stage on every redirect.

---
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches 32-bit words over a req/ack
// handshake, slices them for the control stage, and handles stalls and branches.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4,
    parameter logic [4:0]      NOP_OP   = 5'd16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [4:0]      opcode,
    output logic [3:0]      reg3_addr,
    output logic [15:0]     offset,
    output logic            instr_fetch,
    output logic            branch_flush,
    output logic [PC_W-1:0] pc_out,
    output logic            fsm_state
);

    // Handshake: imem_req, once high, holds with a constant imem_addr until a
    // cycle with imem_ack=1; the word is taken on that edge. imem_ack is
    // meaningless while imem_req=0.

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic [4:0]      op_q, op_d;
    logic [3:0]      r3_q, r3_d;
    logic [15:0]     off_q, off_d;
    logic            vld_q, vld_d;
    logic            flush_q, flush_d;
    logic [PC_W-1:0] pcout_q, pcout_d;
    logic            skid_vld_q, skid_vld_d;
    logic [4:0]      skid_op_q, skid_op_d;
    logic [3:0]      skid_r3_q, skid_r3_d;
    logic [15:0]     skid_off_q, skid_off_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;

    logic            ack_v;
    logic [4:0]      w_op;
    logic [3:0]      w_r3;
    logic [15:0]     w_off;
    logic            unused_rdata;

    assign ack_v        = imem_ack & req_q;
    assign w_op         = imem_rdata[31:27];
    assign w_r3         = imem_rdata[26:23];
    assign w_off        = imem_rdata[15:0];
    assign unused_rdata = ^imem_rdata[22:16];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        req_d      = req_q;
        op_d       = op_q;
        r3_d       = r3_q;
        off_d      = off_q;
        vld_d      = vld_q;
        flush_d    = 1'b0;
        pcout_d    = pcout_q;
        skid_vld_d = skid_vld_q;
        skid_op_d  = skid_op_q;
        skid_r3_d  = skid_r3_q;
        skid_off_d = skid_off_q;
        skid_pc_d  = skid_pc_q;

        if (branch_taken) begin
            flush_d    = 1'b1;
            op_d       = NOP_OP;
            r3_d       = '0;
            off_d      = '0;
            vld_d      = 1'b0;
            skid_vld_d = 1'b0;
            // An outstanding request must finish before the address may change.
            if (!req_q || ack_v) begin
                pc_d    = branch_target;
                req_d   = 1'b1;
                state_d = RUN;
            end else begin
                tgt_d   = branch_target;
                state_d = DRAIN;
            end
        end else if (state_q == DRAIN) begin
            if (ack_v) begin
                pc_d    = tgt_q;
                req_d   = 1'b1;
                state_d = RUN;
            end
        end else if (stall) begin
            if (ack_v) begin
                skid_vld_d = 1'b1;
                skid_op_d  = w_op;
                skid_r3_d  = w_r3;
                skid_off_d = w_off;
                skid_pc_d  = pc_q;
                pc_d       = pc_q + STEP;
                req_d      = 1'b0;
            end else begin
                req_d = !skid_vld_q;
            end
        end else if (skid_vld_q) begin
            // imem_req is low while the buffer is full, so no ack competes here.
            op_d       = skid_op_q;
            r3_d       = skid_r3_q;
            off_d      = skid_off_q;
            vld_d      = 1'b1;
            pcout_d    = skid_pc_q;
            skid_vld_d = 1'b0;
            req_d      = 1'b1;
        end else if (ack_v) begin
            op_d    = w_op;
            r3_d    = w_r3;
            off_d   = w_off;
            vld_d   = 1'b1;
            pcout_d = pc_q;
            pc_d    = pc_q + STEP;
            req_d   = 1'b1;
        end else begin
            op_d  = NOP_OP;
            r3_d  = '0;
            off_d = '0;
            vld_d = 1'b0;
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            req_q      <= 1'b0;
            op_q       <= NOP_OP;
            r3_q       <= '0;
            off_q      <= '0;
            vld_q      <= 1'b0;
            flush_q    <= 1'b0;
            pcout_q    <= '0;
            skid_vld_q <= 1'b0;
            skid_op_q  <= NOP_OP;
            skid_r3_q  <= '0;
            skid_off_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            req_q      <= req_d;
            op_q       <= op_d;
            r3_q       <= r3_d;
            off_q      <= off_d;
            vld_q      <= vld_d;
            flush_q    <= flush_d;
            pcout_q    <= pcout_d;
            skid_vld_q <= skid_vld_d;
            skid_op_q  <= skid_op_d;
            skid_r3_q  <= skid_r3_d;
            skid_off_q <= skid_off_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign opcode       = op_q;
    assign reg3_addr    = r3_q;
    assign offset       = off_q;
    assign instr_fetch  = vld_q;
    assign branch_flush = flush_q;
    assign pc_out       = pcout_q;
    assign fsm_state    = (state_q == DRAIN);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [4:0]  opcode;
    logic [3:0]  reg3_addr;
    logic [15:0] offset;
    logic        instr_fetch;
    logic        branch_flush;
    logic [15:0] pc_out;
    logic        fsm_state;

    int n_vec = 0;
    int n_bad = 0;

    // memory model controls
    logic        mem_en = 1'b1;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    assign imem_ack   = mem_en ? mem_ack : man_ack;
    assign imem_rdata = mem_en ? mem_rdata : man_rdata;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .opcode(opcode), .reg3_addr(reg3_addr), .offset(offset),
        .instr_fetch(instr_fetch), .branch_flush(branch_flush),
        .pc_out(pc_out), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        logic [4:0] op;
        logic [3:0] r;
        op = 5'd6 + a[6:2];
        r  = 4'd3 + a[5:2];
        return {op, r, 7'd0, 16'h0010 + a};
    endfunction

    // Memory: acks after mem_lat idle cycles of a held request.
    always @(posedge clk) begin
        #1;
        if (!mem_en) begin
            mem_cnt = 0;
        end else if (!imem_req) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_cnt >= mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = word_at(imem_addr);
            mem_cnt   = 0;
        end else begin
            mem_ack = 1'b0;
            mem_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int lat);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        mem_en = 1'b1; mem_lat = lat; man_ack = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        mem_en = 1'b1; mem_lat = 0;
        step(); step();
        n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0b want 0", imem_req); end
        n_vec++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
        n_vec++; if (opcode !== 5'd16) begin n_bad++; $display("FAIL rst_opcode: got %0d want 16", opcode); end
        n_vec++; if (reg3_addr !== 4'd0) begin n_bad++; $display("FAIL rst_reg3: got %0d want 0", reg3_addr); end
        n_vec++; if (offset !== 16'h0000) begin n_bad++; $display("FAIL rst_offset: got %h want 0000", offset); end
        n_vec++; if (instr_fetch !== 1'b0) begin n_bad++; $display("FAIL rst_fetch: got %0b want 0", instr_fetch); end
        n_vec++; if (branch_flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %0b want 0", branch_flush); end
        n_vec++; if (pc_out !== 16'h0000) begin n_bad++; $display("FAIL rst_pc_out: got %h want 0000", pc_out); end
        n_vec++; if (fsm_state !== 1'b0) begin n_bad++; $display("FAIL rst_state: got %0b want 0", fsm_state); end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        do_reset(0);
        step();
        n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL zw_req1: got %0b want 1", imem_req); end
        n_vec++; if (instr_fetch !== 1'b0) begin n_bad++; $display("FAIL zw_fetch1: got %0b want 0", instr_fetch); end
        step();
        n_vec++; if (opcode !== 5'd6) begin n_bad++; $display("FAIL zw_op0: got %0d want 6", opcode); end
        n_vec++; if (reg3_addr !== 4'd3) begin n_bad++; $display("FAIL zw_r3_0: got %0d want 3", reg3_addr); end
        n_vec++; if (offset !== 16'h0010) begin n_bad++; $display("FAIL zw_off0: got %h want 0010", offset); end
        n_vec++; if (pc_out !== 16'h0000) begin n_bad++; $display("FAIL zw_pc0: got %h want 0000", pc_out); end
        n_vec++; if (instr_fetch !== 1'b1) begin n_bad++; $display("FAIL zw_fetch2: got %0b want 1", instr_fetch); end
        n_vec++; if (imem_addr !== 16'h0004) begin n_bad++; $display("FAIL zw_addr2: got %h want 0004", imem_addr); end
        step();
        n_vec++; if (pc_out !== 16'h0004) begin n_bad++; $display("FAIL zw_pc4: got %h want 0004", pc_out); end
        n_vec++; if (opcode !== 5'd7) begin n_bad++; $display("FAIL zw_op4: got %0d want 7", opcode); end
        step();
        n_vec++; if (pc_out !== 16'h0008) begin n_bad++; $display("FAIL zw_pc8: got %h want 0008", pc_out); end
        n_vec++; if (offset !== 16'h0018) begin n_bad++; $display("FAIL zw_off8: got %h want 0018", offset); end
        n_vec++; if (instr_fetch !== 1'b1) begin n_bad++; $display("FAIL zw_fetch4: got %0b want 1", instr_fetch); end
    endtask

    task automatic test_latency();
        do_reset(2);
        step();
        step();
        n_vec++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_bad++; $display("FAIL lat_hold2: got req %0b addr %h want 1 0000", imem_req, imem_addr); end
        step();
        n_vec++; if (imem_addr !== 16'h0000 || instr_fetch !== 1'b0) begin n_bad++; $display("FAIL lat_hold3: got addr %h fetch %0b want 0000 0", imem_addr, instr_fetch); end
        step();
        n_vec++; if (instr_fetch !== 1'b1 || pc_out !== 16'h0000) begin n_bad++; $display("FAIL lat_word0: got fetch %0b pc %h want 1 0000", instr_fetch, pc_out); end
        n_vec++; if (imem_addr !== 16'h0004) begin n_bad++; $display("FAIL lat_addr4: got %h want 0004", imem_addr); end
        step();
        n_vec++; if (instr_fetch !== 1'b0 || opcode !== 5'd16) begin n_bad++; $display("FAIL lat_gap1: got fetch %0b op %0d want 0 16", instr_fetch, opcode); end
        step();
        n_vec++; if (instr_fetch !== 1'b0) begin n_bad++; $display("FAIL lat_gap2: got %0b want 0", instr_fetch); end
        step();
        n_vec++; if (instr_fetch !== 1'b1 || pc_out !== 16'h0004 || opcode !== 5'd7) begin n_bad++; $display("FAIL lat_word4: got fetch %0b pc %h op %0d want 1 0004 7", instr_fetch, pc_out, opcode); end
    endtask

    task automatic test_stall();
        do_reset(0);
        step(); step(); step();
        stall = 1'b1;
        step();
        n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL st_req_drop: got %0b want 0", imem_req); end
        n_vec++; if (pc_out !== 16'h0004 || opcode !== 5'd7 || instr_fetch !== 1'b1) begin n_bad++; $display("FAIL st_hold1: got pc %h op %0d fetch %0b want 0004 7 1", pc_out, opcode, instr_fetch); end
        step(); step(); step();
        n_vec++; if (pc_out !== 16'h0004 || opcode !== 5'd7) begin n_bad++; $display("FAIL st_hold4: got pc %h op %0d want 0004 7", pc_out, opcode); end
        n_vec++; if (imem_req !== 1'b0 || imem_addr !== 16'h000C) begin n_bad++; $display("FAIL st_req4: got req %0b addr %h want 0 000c", imem_req, imem_addr); end
        stall = 1'b0;
        step();
        n_vec++; if (pc_out !== 16'h0008 || opcode !== 5'd8 || reg3_addr !== 4'd5 || offset !== 16'h0018) begin n_bad++; $display("FAIL st_skid: got pc %h op %0d r3 %0d off %h want 0008 8 5 0018", pc_out, opcode, reg3_addr, offset); end
        n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL st_req_up: got %0b want 1", imem_req); end
        step();
        n_vec++; if (pc_out !== 16'h000C || opcode !== 5'd9 || instr_fetch !== 1'b1) begin n_bad++; $display("FAIL st_resume: got pc %h op %0d fetch %0b want 000c 9 1", pc_out, opcode, instr_fetch); end
    endtask

    task automatic test_branch_drain();
        do_reset(2);
        for (int i = 0; i < 10; i++) step();
        n_vec++; if (pc_out !== 16'h0008 || imem_addr !== 16'h000C) begin n_bad++; $display("FAIL br_pre: got pc %h addr %h want 0008 000c", pc_out, imem_addr); end
        branch_taken = 1'b1; branch_target = 16'h0040;
        step();
        branch_taken = 1'b0; branch_target = 16'h0000;
        n_vec++; if (branch_flush !== 1'b1) begin n_bad++; $display("FAIL br_flush: got %0b want 1", branch_flush); end
        n_vec++; if (instr_fetch !== 1'b0 || opcode !== 5'd16) begin n_bad++; $display("FAIL br_nop: got fetch %0b op %0d want 0 16", instr_fetch, opcode); end
        n_vec++; if (fsm_state !== 1'b1 || imem_addr !== 16'h000C || imem_req !== 1'b1) begin n_bad++; $display("FAIL br_drain: got st %0b addr %h req %0b want 1 000c 1", fsm_state, imem_addr, imem_req); end
        step();
        n_vec++; if (branch_flush !== 1'b0 || imem_addr !== 16'h000C) begin n_bad++; $display("FAIL br_drain2: got flush %0b addr %h want 0 000c", branch_flush, imem_addr); end
        step();
        n_vec++; if (imem_addr !== 16'h0040 || instr_fetch !== 1'b0 || fsm_state !== 1'b0) begin n_bad++; $display("FAIL br_redirect: got addr %h fetch %0b st %0b want 0040 0 0", imem_addr, instr_fetch, fsm_state); end
        step(); step(); step();
        n_vec++; if (pc_out !== 16'h0040 || opcode !== 5'd22 || reg3_addr !== 4'd3 || offset !== 16'h0050 || instr_fetch !== 1'b1) begin n_bad++; $display("FAIL br_first: got pc %h op %0d r3 %0d off %h fetch %0b want 0040 22 3 0050 1", pc_out, opcode, reg3_addr, offset, instr_fetch); end
    endtask

    task automatic test_branch_stall();
        do_reset(0);
        step(); step(); step();
        stall = 1'b1;
        step();
        branch_taken = 1'b1; branch_target = 16'h0080;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        n_vec++; if (branch_flush !== 1'b1 || opcode !== 5'd16 || instr_fetch !== 1'b0) begin n_bad++; $display("FAIL bs_flush: got flush %0b op %0d fetch %0b want 1 16 0", branch_flush, opcode, instr_fetch); end
        n_vec++; if (imem_addr !== 16'h0080 || imem_req !== 1'b1) begin n_bad++; $display("FAIL bs_addr: got addr %h req %0b want 0080 1", imem_addr, imem_req); end
        step();
        n_vec++; if (pc_out !== 16'h0080 || opcode !== 5'd6 || offset !== 16'h0090 || branch_flush !== 1'b0) begin n_bad++; $display("FAIL bs_first: got pc %h op %0d off %h flush %0b want 0080 6 0090 0", pc_out, opcode, offset, branch_flush); end
    endtask

    task automatic test_reset_mid();
        do_reset(3);
        step();
        mem_en = 1'b0; man_ack = 1'b0;
        rst = 1'b1;
        step();
        n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req: got %0b want 0", imem_req); end
        man_ack = 1'b1; man_rdata = 32'hFFFF_FFFF;
        rst = 1'b0;
        step();
        n_vec++; if (instr_fetch !== 1'b0 || opcode !== 5'd16 || reg3_addr !== 4'd0 || offset !== 16'h0000 || pc_out !== 16'h0000) begin n_bad++; $display("FAIL rm_ignored: got fetch %0b op %0d r3 %0d off %h pc %h want 0 16 0 0000 0000", instr_fetch, opcode, reg3_addr, offset, pc_out); end
        n_vec++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin n_bad++; $display("FAIL rm_restart: got addr %h req %0b want 0000 1", imem_addr, imem_req); end
        man_ack = 1'b0; mem_lat = 0; mem_en = 1'b1;
        step(); step();
        n_vec++; if (instr_fetch !== 1'b1 || pc_out !== 16'h0000 || opcode !== 5'd6) begin n_bad++; $display("FAIL rm_first: got fetch %0b pc %h op %0d want 1 0000 6", instr_fetch, pc_out, opcode); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_branch_drain();
        test_branch_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
